// File: rtl/rst_pulse_gen_pkg.sv
// Shared types and constants for the reset pulse generator.
package rst_pulse_gen_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StWaitAck = 2'd2
    } state_e;

    // Reset cause codes reported on CAUSE.
    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseSw   = 2'b01;
    localparam logic [1:0] CauseWdog = 2'b10;
    localparam logic [1:0] CauseBoth = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_pulse_ack_sync.sv
// Flop chain bringing the asynchronous ACK_IN into the reference-clock domain.
module rst_pulse_ack_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift register with synchronous clear; no enable.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_pulse_gen.sv
// Reset pulse generator: converts software/watchdog requests into a minimum-width active-low
// reset and reports when the destination domain has come back out of reset.
// Optional feature: define RST_PULSE_GEN_CAUSE_EN to add the CAUSE output and cause register.
module rst_pulse_gen #(
    parameter int unsigned PULSE_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT  = 256,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW_RST_REQ,
    input  logic       WDOG_REQ,
    input  logic       ACK_IN,
    output logic       RST_OUT_N,
    output logic       BUSY,
    output logic       DONE,
    output logic       TIMEOUT
`ifdef RST_PULSE_GEN_CAUSE_EN
    ,
    output logic [1:0] CAUSE
`endif
);

    import rst_pulse_gen_pkg::*;

    localparam int unsigned CntMax = max_u(PULSE_CYCLES, ACK_TIMEOUT);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] AckLoad   = CntW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rst_out_n_q, rst_out_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            ack_low_seen_q, ack_low_seen_d;
    logic            ack_s;
    logic            req;

    assign req = SW_RST_REQ | WDOG_REQ;

    rst_pulse_ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .CLK(CLK),
        .CLR(RST),
        .D  (ACK_IN),
        .Q  (ack_s)
    );

    // Next-state and registered-output values for the request/pulse/ack sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rst_out_n_d    = rst_out_n_q;
        done_d         = 1'b0;
        timeout_d      = timeout_q;
        ack_low_seen_d = ack_low_seen_q;

        unique case (state_q)
            StIdle: begin
                rst_out_n_d = 1'b1;
                if (req) begin
                    state_d        = StAssert;
                    cnt_d          = PulseLoad;
                    rst_out_n_d    = 1'b0;
                    timeout_d      = 1'b0;
                    ack_low_seen_d = 1'b0;
                end
            end
            StAssert: begin
                rst_out_n_d = 1'b0;
                // Destination should drop its ack while held in reset.
                if (!ack_s) ack_low_seen_d = 1'b1;
                if (req) begin
                    cnt_d = PulseLoad;
                end else if (cnt_q == '0) begin
                    state_d     = StWaitAck;
                    cnt_d       = AckLoad;
                    rst_out_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWaitAck: begin
                rst_out_n_d = 1'b1;
                if (req) begin
                    state_d        = StAssert;
                    cnt_d          = PulseLoad;
                    rst_out_n_d    = 1'b0;
                    timeout_d      = 1'b0;
                    ack_low_seen_d = 1'b0;
                end else if (ack_s && ack_low_seen_q) begin
                    // Only a high ack that follows an observed low counts as a release.
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                    if (!ack_s) ack_low_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset starts a full pulse once RST falls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StAssert;
            cnt_q          <= PulseLoad;
            rst_out_n_q    <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            ack_low_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rst_out_n_q    <= rst_out_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            ack_low_seen_q <= ack_low_seen_d;
        end
    end

    assign RST_OUT_N = rst_out_n_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TIMEOUT   = timeout_q;

`ifdef RST_PULSE_GEN_CAUSE_EN
    logic [1:0] req_cause;
    logic [1:0] cause_q, cause_d;

    // Encode which request sources are active this cycle.
    always_comb begin
        req_cause = CauseNone;
        if (SW_RST_REQ && WDOG_REQ) req_cause = CauseBoth;
        else if (SW_RST_REQ)        req_cause = CauseSw;
        else if (WDOG_REQ)          req_cause = CauseWdog;
    end

    // Fresh entry latches the sources; while asserting they accumulate.
    always_comb begin
        cause_d = cause_q;
        if (state_q == StAssert) begin
            cause_d = cause_q | req_cause;
        end else if (req) begin
            cause_d = req_cause;
        end
    end

    // Cause register, held through IDLE until the next request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cause_q <= CauseNone;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign CAUSE = cause_q;
`else
    // Cause tracking compiled out: request sources are not recorded.
`endif

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Self-checking bench for rst_pulse_gen: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed pulse lengths and latencies.
module tb_rst_pulse_gen;

    localparam int unsigned P = 16;
    localparam int unsigned T = 256;
    localparam int unsigned S = 2;

    logic CLK = 1'b0;
    logic RST, SW_RST_REQ, WDOG_REQ, ACK_IN;
    logic RST_OUT_N, BUSY, DONE, TIMEOUT;
`ifdef RST_PULSE_GEN_CAUSE_EN
    logic [1:0] CAUSE;
`endif

    always #5 CLK = ~CLK;

    rst_pulse_gen #(
        .PULSE_CYCLES(P),
        .ACK_TIMEOUT (T),
        .SYNC_STAGES (S)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(SW_RST_REQ),
        .WDOG_REQ  (WDOG_REQ),
        .ACK_IN    (ACK_IN),
        .RST_OUT_N (RST_OUT_N),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TIMEOUT   (TIMEOUT)
`ifdef RST_PULSE_GEN_CAUSE_EN
        ,
        .CAUSE     (CAUSE)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute edge numbers for pulse end and ack deadline.
    int  edge_n = 0;
    bit  m_valid = 1'b0;
    bit  m_rst_n, m_busy, m_done, m_timeout, m_seen;
    bit  [1:0] m_cause;
    int  low_until, deadline;
    bit  pipe [S];

    always @(posedge CLK) begin : model
        bit ack_s, req;
        bit [1:0] rc;
        edge_n++;
        ack_s = pipe[S-1];
        for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = ACK_IN;
        req = SW_RST_REQ | WDOG_REQ;
        rc  = {WDOG_REQ, SW_RST_REQ};
        m_done = 1'b0;
        if (RST === 1'b1) begin
            m_rst_n = 1'b0; m_busy = 1'b1; m_timeout = 1'b0; m_cause = 2'b00;
            m_seen = 1'b0; low_until = edge_n + P;
            for (int i = 0; i < S; i++) pipe[i] = 1'b0;
            m_valid = 1'b1;
        end else if (!m_rst_n) begin
            if (!ack_s) m_seen = 1'b1;
            m_cause = m_cause | rc;
            if (req) low_until = edge_n + P;
            if (edge_n >= low_until) begin
                m_rst_n = 1'b1;
                deadline = edge_n + T;
            end
        end else if (m_busy) begin
            if (req) begin
                m_rst_n = 1'b0; m_timeout = 1'b0; m_seen = 1'b0;
                m_cause = rc; low_until = edge_n + P;
            end else if (ack_s && m_seen) begin
                m_done = 1'b1; m_busy = 1'b0;
            end else if (edge_n >= deadline) begin
                m_timeout = 1'b1; m_busy = 1'b0;
            end else if (!ack_s) begin
                m_seen = 1'b1;
            end
        end else if (req) begin
            m_rst_n = 1'b0; m_busy = 1'b1; m_timeout = 1'b0; m_seen = 1'b0;
            m_cause = rc; low_until = edge_n + P;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge CLK) begin
        if (DONE === 1'b1) done_pulses++;
        if (m_valid) begin
            check("model RST_OUT_N", 32'(RST_OUT_N), 32'(m_rst_n));
            check("model BUSY", 32'(BUSY), 32'(m_busy));
            check("model DONE", 32'(DONE), 32'(m_done));
            check("model TIMEOUT", 32'(TIMEOUT), 32'(m_timeout));
`ifdef RST_PULSE_GEN_CAUSE_EN
            check("model CAUSE", 32'(CAUSE), 32'(m_cause));
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return RST_OUT_N;
            1:       return DONE;
            default: return TIMEOUT;
        endcase
    endfunction

    // Tick until the selected output is high; n = edges taken (stops at max).
    task automatic wait_for(input int which, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sel(which) !== 1'b1 && n < max);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n, d0;
        RST = 1'b1; SW_RST_REQ = 1'b0; WDOG_REQ = 1'b0; ACK_IN = 1'b0;

        // 1: power-on pulse, then ack rise.
        tick();
        check("reset RST_OUT_N", 32'(RST_OUT_N), 0);
        check("reset BUSY", 32'(BUSY), 1);
        check("reset DONE", 32'(DONE), 0);
        check("reset TIMEOUT", 32'(TIMEOUT), 0);
        tick(); tick();
        RST = 1'b0;
        wait_for(0, 100, n);
        check("t1 pulse length", n, 16);
        repeat (4) tick();
        ACK_IN = 1'b1;
        wait_for(1, 20, n);
        check("t1 done latency", n, 3);
        check("t1 busy with done", 32'(BUSY), 0);
        tick();
        check("t1 done one cycle", 32'(DONE), 0);

        // 2: stale high ack must not complete.
        tick(); tick();
        SW_RST_REQ = 1'b1;
        tick();
        check("t2 req latency", 32'(RST_OUT_N), 0);
        SW_RST_REQ = 1'b0;
        wait_for(0, 100, n);
        check("t2 pulse length", n, 16);
        d0 = done_pulses;
        repeat (20) tick();
        check("t2 no done on stale ack", done_pulses - d0, 0);
        ACK_IN = 1'b0;
        repeat (4) tick();
        ACK_IN = 1'b1;
        wait_for(1, 20, n);
        check("t2 done after low-high", n, 3);

        // 3: ack stuck low -> timeout.
        ACK_IN = 1'b0;
        tick();
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        wait_for(0, 100, n);
        check("t3 pulse length", n, 16);
        d0 = done_pulses;
        wait_for(2, 400, n);
        check("t3 timeout cycles", n, 256);
        check("t3 idle after timeout", 32'(BUSY), 0);
        check("t3 no done", done_pulses - d0, 0);

        // 4: watchdog on the 10th assert cycle extends the pulse.
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        check("t4 timeout cleared", 32'(TIMEOUT), 0);
        repeat (9) tick();
        WDOG_REQ = 1'b1;
        tick();
        WDOG_REQ = 1'b0;
        wait_for(0, 100, n);
        check("t4 extended pulse", 10 + n, 26);
`ifdef RST_PULSE_GEN_CAUSE_EN
        check("t4 cause both", 32'(CAUSE), 3);
`endif
        ACK_IN = 1'b1;
        wait_for(1, 20, n);
        check("t4 done latency", n, 3);
`ifdef RST_PULSE_GEN_CAUSE_EN
        tick();
        check("t4 cause held in idle", 32'(CAUSE), 3);
`endif

        // 5: request on the accept cycle wins.
        ACK_IN = 1'b0;
        tick(); tick();
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        wait_for(0, 100, n);
        check("t5 first pulse", n, 16);
        ACK_IN = 1'b1;
        tick(); tick();
        d0 = done_pulses;
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        check("t5 no done on collision", 32'(DONE), 0);
        check("t5 new pulse starts", 32'(RST_OUT_N), 0);
        wait_for(0, 100, n);
        check("t5 new pulse length", 1 + n, 16 + 1);
        wait_for(2, 400, n);
        check("t5 stale ack times out", n, 256);
        check("t5 no done at all", done_pulses - d0, 0);

        // 6: RST with TIMEOUT set, then RST mid-wait.
        RST = 1'b1;
        tick();
        check("t6 rst RST_OUT_N", 32'(RST_OUT_N), 0);
        check("t6 rst TIMEOUT", 32'(TIMEOUT), 0);
        check("t6 rst BUSY", 32'(BUSY), 1);
`ifdef RST_PULSE_GEN_CAUSE_EN
        check("t6 rst CAUSE", 32'(CAUSE), 0);
`endif
        RST = 1'b0;
        wait_for(0, 100, n);
        check("t6 pulse after rst", n, 16);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        check("t6 mid-wait rst", 32'(RST_OUT_N), 0);
        RST = 1'b0;
        wait_for(0, 100, n);
        check("t6 pulse after mid-wait rst", n, 16);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
